// File: rtl/tmr_pwm_pkg.sv
// Shared constants and helpers for the TMR motion/drive path.
// Used by the controllers, the voter and the PWM drive stage.
package tmr_pwm_pkg;

  localparam int PWM_MAX = 15;
  localparam logic [3:0] DEFAULT_DIR = 4'd8;

  function automatic logic [7:0] maj3(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return (a & b) | (b & c) | (a & c);
  endfunction

  function automatic logic [3:0] clamp4(
    input logic signed [5:0] x
  );
    if (x < 6'sd0) return 4'd0;
    if (x > 6'sd15) return 4'(PWM_MAX);
    return x[3:0];
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Bitwise 2-of-3 majority voter with per-replica disagreement flags.
// Purely combinational; width is a parameter so it can be reused.
module tmr_vote3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] v,
  output logic [2:0]       mis
);

  // Majority per bit, then flag each replica that differs from it.
  always_comb begin
    v   = (a & b) | (b & c) | (a & c);
    mis = {c != v, b != v, a != v};
  end

endmodule

// File: rtl/tmr_pwm_drive.sv
// Motor drive stage: votes three speed/dir replicas, mixes them into
// left/right duties, drives two PWMs and tracks per-replica faults.
module tmr_pwm_drive #(
  parameter int         PRESCALE    = 4,
  parameter int         FAULT_LIMIT = 3,
  parameter logic [3:0] DEFAULT_DIR = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] speed_a,
  input  logic [3:0] speed_b,
  input  logic [3:0] speed_c,
  input  logic [3:0] dir_a,
  input  logic [3:0] dir_b,
  input  logic [3:0] dir_c,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [3:0] duty_l,
  output logic [3:0] duty_r,
  output logic       period_start,
  output logic [2:0] fault
);

  import tmr_pwm_pkg::*;

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(PRESCALE - 1);
  localparam logic [3:0] CNT_LAST =
    4'(PWM_MAX - 1);
  localparam logic [3:0] LIM = 4'(FAULT_LIMIT);

  logic [PW-1:0]     pre;
  logic [3:0]        cnt;
  logic              tick;
  logic              samp;
  logic [7:0]        v;
  logic [2:0]        mis;
  logic [3:0]        speed_v;
  logic [3:0]        dir_v;
  logic signed [5:0] d;
  logic signed [5:0] ls;
  logic signed [5:0] rs;
  logic [3:0]        l;
  logic [3:0]        r;
  logic [3:0]        m     [3];
  logic [3:0]        m_nxt [3];
  logic [2:0]        hit;

  tmr_vote3 #(.WIDTH(8)) u_vote (
    .a   ({speed_a, dir_a}),
    .b   ({speed_b, dir_b}),
    .c   ({speed_c, dir_c}),
    .v   (v),
    .mis (mis)
  );

  assign speed_v = v[7:4];
  assign dir_v   = v[3:0];
  assign tick    = (pre == PRE_LAST);
  assign samp    = en && tick && (cnt == CNT_LAST);

  // Differential mix of the voted pair, with the stop overrides.
  always_comb begin
    d  = $signed({2'b00, dir_v})
       - $signed({2'b00, DEFAULT_DIR});
    ls = $signed({2'b00, speed_v}) + d;
    rs = $signed({2'b00, speed_v}) - d;
    l  = clamp4(ls);
    r  = clamp4(rs);
    if (speed_v == 4'd0 || $countones(fault) >= 2) begin
      l = 4'd0;
      r = 4'd0;
    end
  end

  // Next mismatch streak per replica and whether it hits the limit.
  always_comb begin
    hit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m_nxt[i] = 4'd0;
      if (mis[i])
        m_nxt[i] = (m[i] >= LIM) ? LIM : m[i] + 4'd1;
      hit[i] = (m_nxt[i] == LIM);
    end
  end

  // Prescaler and PWM period counter; both park at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= 4'd0;
    end else if (!en) begin
      pre <= '0;
      cnt <= 4'd0;
    end else if (tick) begin
      pre <= '0;
      cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Duty latch at end of period, period marker and PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_l       <= 4'd0;
      duty_r       <= 4'd0;
      pwm_l        <= 1'b0;
      pwm_r        <= 1'b0;
      period_start <= 1'b0;
    end else if (!en) begin
      duty_l       <= 4'd0;
      duty_r       <= 4'd0;
      pwm_l        <= 1'b0;
      pwm_r        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_l        <= (cnt < duty_l);
      pwm_r        <= (cnt < duty_r);
      period_start <= samp;
      if (samp) begin
        duty_l <= l;
        duty_r <= r;
      end
    end
  end

  // Mismatch streaks and sticky fault flags, updated once per period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        m[i] <= 4'd0;
      fault <= 3'b000;
    end else if (samp) begin
      for (int i = 0; i < 3; i++)
        m[i] <= m_nxt[i];
      fault <= fault | hit;
    end
  end

endmodule
